// File: rtl/map_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | map_scan_ctrl: raster-walks one map in BRAM and streams (tile_id, x, y) to |
// | the tile renderer, drawing HERO_TILE at the player's cell.  Rev 1.0         |
// +----------------------------------------------------------------------------+
module map_scan_ctrl #(
  parameter int                MAP_WIDTH  = 16,
  parameter int                MAP_HEIGHT = 16,
  parameter int                ADDR_W     = 19,
  parameter int                TILE_W     = 16,
  parameter int                RD_LAT     = 1,
  parameter logic [TILE_W-1:0] HERO_TILE  = 16'h0040
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [15:0]       map_id,
  input  logic [3:0]        player_x,
  input  logic [3:0]        player_y,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] bram_map_addr,
  input  logic [TILE_W-1:0] bram_map_data,
  output logic              tile_valid,
  input  logic              tile_ready,
  output logic [TILE_W-1:0] tile_id,
  output logic [3:0]        grid_x,
  output logic [3:0]        grid_y
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [TILE_W-1:0]   tile_q, tile_d;
  logic [3:0]          gx_q, gx_d, gy_q, gy_d;
  logic [3:0]          px_q, px_d, py_q, py_d;
  logic [15:0]         map_q, map_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                last_col, last_cell;
  logic [3:0]          nx, ny;

  // Address arithmetic wraps modulo 2^ADDR_W, so large map IDs alias low.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [15:0] m,
                                                   input logic [3:0]  x,
                                                   input logic [3:0]  y);
    return ADDR_W'({m, 8'h00}) + ADDR_W'(y) * ADDR_W'(MAP_WIDTH) + ADDR_W'(x);
  endfunction

  assign last_col  = (gx_q == 4'(MAP_WIDTH - 1));
  assign last_cell = last_col && (gy_q == 4'(MAP_HEIGHT - 1));
  assign nx        = last_col ? 4'd0 : gx_q + 4'd1;
  assign ny        = last_col ? gy_q + 4'd1 : gy_q;

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    addr_d  = addr_q;
    tile_d  = tile_q;
    gx_d    = gx_q;
    gy_d    = gy_q;
    px_d    = px_q;
    py_d    = py_q;
    map_d   = map_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          map_d   = map_id;
          px_d    = player_x;
          py_d    = player_y;
          gx_d    = 4'd0;
          gy_d    = 4'd0;
          busy_d  = 1'b1;
          addr_d  = cell_addr(map_id, 4'd0, 4'd0);
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        cnt_d   = 2'(RD_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          tile_d  = (gx_q == px_q && gy_q == py_q) ? HERO_TILE : bram_map_data;
          valid_d = 1'b1;
          state_d = S_ISSUE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_ISSUE: begin
        if (tile_ready) begin
          valid_d = 1'b0;
          if (last_cell) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            gx_d    = nx;
            gy_d    = ny;
            addr_d  = cell_addr(map_q, nx, ny);
            state_d = S_ADDR;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      tile_q  <= '0;
      gx_q    <= 4'd0;
      gy_q    <= 4'd0;
      px_q    <= 4'd0;
      py_q    <= 4'd0;
      map_q   <= 16'd0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      tile_q  <= tile_d;
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      px_q    <= px_d;
      py_q    <= py_d;
      map_q   <= map_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign tile_valid    = valid_q;
  assign bram_map_addr = addr_q;
  assign tile_id       = tile_q;
  assign grid_x        = gx_q;
  assign grid_y        = gy_q;

endmodule
`default_nettype wire

// File: tb/tb_map_scan_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_map_scan_ctrl: randomized scans of map_scan_ctrl (RD_LAT 1 and 3)       |
// | checked against a raster-order descriptor model.  Rev 1.0                  |
// +----------------------------------------------------------------------------+
module tb_map_scan_ctrl;
  localparam int          MW   = 16;
  localparam int          MH   = 16;
  localparam int          AW   = 19;
  localparam int          TW   = 16;
  localparam logic [15:0] HERO = 16'h0040;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start1 = 1'b0, start3 = 1'b0;
  logic          tile_ready = 1'b0;
  logic [15:0]   map_id = 16'd0;
  logic [3:0]    player_x = 4'd0, player_y = 4'd0;

  logic          busy1, done1, valid1, busy3, done3, valid3;
  logic [AW-1:0] addr1, addr3;
  logic [TW-1:0] tid1, tid3, bd1;
  logic [TW-1:0] pipe3 [3];
  logic [TW-1:0] bd3;
  logic [3:0]    gx1, gy1, gx3, gy3;

  logic          sel3 = 1'b0;
  logic          w_busy, w_done, w_valid;
  logic [AW-1:0] w_addr;
  logic [TW-1:0] w_tid;
  logic [3:0]    w_gx, w_gy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  map_scan_ctrl #(.RD_LAT(1)) dut1 (
    .clk(clk), .rstn(rstn), .start(start1), .map_id(map_id),
    .player_x(player_x), .player_y(player_y), .busy(busy1), .done(done1),
    .bram_map_addr(addr1), .bram_map_data(bd1), .tile_valid(valid1),
    .tile_ready(tile_ready), .tile_id(tid1), .grid_x(gx1), .grid_y(gy1));

  map_scan_ctrl #(.RD_LAT(3)) dut3 (
    .clk(clk), .rstn(rstn), .start(start3), .map_id(map_id),
    .player_x(player_x), .player_y(player_y), .busy(busy3), .done(done3),
    .bram_map_addr(addr3), .bram_map_data(bd3), .tile_valid(valid3),
    .tile_ready(tile_ready), .tile_id(tid3), .grid_x(gx3), .grid_y(gy3));

  // BRAM contents: each word holds the low 16 bits of its own address.
  always @(posedge clk) begin
    bd1      <= addr1[15:0];
    pipe3[0] <= addr3[15:0];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign bd3 = pipe3[2];

  assign w_busy  = sel3 ? busy3  : busy1;
  assign w_done  = sel3 ? done3  : done1;
  assign w_valid = sel3 ? valid3 : valid1;
  assign w_addr  = sel3 ? addr3  : addr1;
  assign w_tid   = sel3 ? tid3   : tid1;
  assign w_gx    = sel3 ? gx3    : gx1;
  assign w_gy    = sel3 ? gy3    : gy1;

  function automatic logic [AW-1:0] exp_addr(input logic [15:0] m, input int idx);
    int a;
    a = (int'(m) * 256 + idx) % (1 << AW);
    return AW'(a);
  endfunction

  function automatic logic [TW-1:0] exp_tile(input logic [15:0] m, input logic [3:0] px,
                                             input logic [3:0] py, input int idx);
    logic [AW-1:0] a;
    if ((idx % MW) == int'(px) && (idx / MW) == int'(py)) return HERO;
    a = exp_addr(m, idx);
    return a[15:0];
  endfunction

  // mode 0: ready always high when valid; 1: random ready; 2: stall 10 cycles at (7,0)
  task automatic run_scan(input bit use3, input logic [15:0] m, input logic [3:0] px,
                          input logic [3:0] py, input int mode, input bit disturb,
                          input int abort_at, input string name);
    int  lat, idx, t, stall;
    bit  saw_done, rdy;
    sel3 = use3;
    lat  = use3 ? 3 : 1;
    @(negedge clk);
    map_id = m; player_x = px; player_y = py;
    if (use3) start3 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start3 = 1'b0;
    map_id = 16'($urandom); player_x = 4'($urandom); player_y = 4'($urandom);
    idx = 0; t = 0; stall = 0; saw_done = 1'b0;
    while (!saw_done && t < 6000) begin
      start1 = 1'b0; start3 = 1'b0;
      if (abort_at >= 0 && idx == abort_at) begin
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({w_busy, w_valid, w_done, w_addr, w_tid, w_gx, w_gy} !== '0)
          begin n_fail++; $display("FAIL %s async_reset: got busy=%b valid=%b done=%b addr=%h tid=%h x=%0d y=%0d, required all zero",
                                   name, w_busy, w_valid, w_done, w_addr, w_tid, w_gx, w_gy); end
        @(negedge clk);
        rstn = 1'b1;
        tile_ready = 1'b0;
        return;
      end
      if (disturb && t == 200) begin
        map_id = 16'd5; player_x = 4'd9; player_y = 4'd1;
        if (use3) start3 = 1'b1; else start1 = 1'b1;
      end
      if (w_done) begin
        saw_done = 1'b1;
        n_checks++;
        if (idx !== MW * MH)
          begin n_fail++; $display("FAIL %s done_count: got %0d handshakes, required %0d", name, idx, MW * MH); end
        if (mode == 0) begin
          n_checks++;
          if (t !== (2 + lat) * MW * MH)
            begin n_fail++; $display("FAIL %s scan_cycles: got %0d, required %0d", name, t, (2 + lat) * MW * MH); end
        end
        n_checks++;
        if (w_busy !== 1'b1 || w_valid !== 1'b0)
          begin n_fail++; $display("FAIL %s done_state: got busy=%b valid=%b, required busy=1 valid=0", name, w_busy, w_valid); end
        if (use3) start3 = 1'b1; else start1 = 1'b1;
      end else begin
        n_checks++;
        if (w_busy !== 1'b1)
          begin n_fail++; $display("FAIL %s busy: got %b at t=%0d, required 1", name, w_busy, t); end
        n_checks++;
        if (w_addr !== exp_addr(m, idx))
          begin n_fail++; $display("FAIL %s addr: got %h at tile %0d, required %h", name, w_addr, idx, exp_addr(m, idx)); end
        if (w_valid) begin
          n_checks++;
          if (w_tid !== exp_tile(m, px, py, idx) || w_gx !== 4'(idx % MW) || w_gy !== 4'(idx / MW))
            begin n_fail++; $display("FAIL %s descriptor: got id=%h (%0d,%0d), required id=%h (%0d,%0d)",
                                     name, w_tid, w_gx, w_gy, exp_tile(m, px, py, idx), idx % MW, idx / MW); end
          case (mode)
            1:       rdy = 1'($urandom);
            2:       if (idx == 7 && stall < 10) begin rdy = 1'b0; stall++; end else rdy = 1'b1;
            default: rdy = 1'b1;
          endcase
          tile_ready = rdy;
          if (rdy) idx++;
        end else begin
          tile_ready = 1'($urandom);
        end
      end
      @(negedge clk);
      t++;
    end
    start1 = 1'b0; start3 = 1'b0;
    tile_ready = 1'b0;
    n_checks++;
    if (!saw_done)
      begin n_fail++; $display("FAIL %s timeout: got no done after %0d cycles, required done", name, t); end
    else begin
      n_checks++;
      if (w_busy !== 1'b0 || w_done !== 1'b0)
        begin n_fail++; $display("FAIL %s post_done: got busy=%b done=%b, required 0 0", name, w_busy, w_done); end
    end
    if (mode == 2) begin
      n_checks++;
      if (stall !== 10)
        begin n_fail++; $display("FAIL %s stall_len: got %0d stalled cycles at (7,0), required 10", name, stall); end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy1, done1, valid1, addr1, tid1, gx1, gy1} !== '0)
      begin n_fail++; $display("FAIL reset_lat1: got busy=%b done=%b valid=%b addr=%h tid=%h, required all zero",
                               busy1, done1, valid1, addr1, tid1); end
    n_checks++;
    if ({busy3, done3, valid3, addr3, tid3, gx3, gy3} !== '0)
      begin n_fail++; $display("FAIL reset_lat3: got busy=%b done=%b valid=%b addr=%h tid=%h, required all zero",
                               busy3, done3, valid3, addr3, tid3); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_scan(1'b0, 16'd2, 4'd3, 4'd5, 0, 1'b0, -1, "basic");
  endtask

  task automatic test_stall();
    run_scan(1'b0, 16'd2, 4'd3, 4'd5, 2, 1'b0, -1, "stall");
  endtask

  task automatic test_midscan_start();
    run_scan(1'b0, 16'd2, 4'd3, 4'd5, 0, 1'b1, -1, "midscan_start");
  endtask

  task automatic test_random();
    for (int i = 0; i < 2; i++)
      run_scan(1'b0, 16'($urandom), 4'($urandom), 4'($urandom), 1, 1'b0, -1, "random");
  endtask

  task automatic test_rdlat3();
    run_scan(1'b1, 16'($urandom), 4'($urandom), 4'($urandom), 0, 1'b0, -1, "rdlat3");
    run_scan(1'b1, 16'($urandom), 4'($urandom), 4'($urandom), 1, 1'b0, -1, "rdlat3_random");
  endtask

  task automatic test_reset_midscan();
    run_scan(1'b0, 16'd2, 4'd3, 4'd5, 0, 1'b0, 100, "abort");
    run_scan(1'b0, 16'd9, 4'd15, 4'd15, 0, 1'b0, -1, "rescan");
  endtask

  task automatic test_map_wrap();
    run_scan(1'b0, 16'hFFFF, 4'd0, 4'd15, 0, 1'b0, -1, "map_wrap");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_midscan_start();
    test_random();
    test_rdlat3();
    test_reset_midscan();
    test_map_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
